vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_cap_pkg.sv | 23 ++
 rtl/sync_edge_detect.sv | 29 ++
 rtl/vga_capture.sv | 191 +++++++++++++++++++
 tb/tb_vga_capture.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cap_pkg.sv
// Shared constants, pixel payload type and FSM state encoding for the VGA capture block.
package vga_cap_pkg;

    localparam int unsigned DEF_WIDTH  = 320;
    localparam int unsigned DEF_HEIGHT = 240;
    localparam int unsigned DEF_ADDR_W = 17;
    localparam int unsigned RGB_W      = 24;

    // One pixel as carried on the input bus and written to the frame buffer.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACT = 2'd1,
        LINE     = 2'd2,
        HBLANK   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Input register (S1) plus a one-cycle-delayed copy used to flag rising/falling edges of S1.
module sync_edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic q_prev;

    // S1 capture and previous-value history, both reset to the idle level of the signal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= RST_VAL;
            q_prev <= RST_VAL;
        end else begin
            q      <= d;
            q_prev <= q;
        end
    end

    assign rise_c = q & ~q_prev;
    assign fall_c = ~q & q_prev;

endmodule

// File: rtl/vga_capture.sv
// Captures a VGA pixel stream into a frame buffer with 2:1 decimation in both axes,
// flags geometry errors and reports frame completion and timing lock.
module vga_capture
    import vga_cap_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iHS,
    input  logic              iVS,
    input  logic              iBLANK_n,
    input  logic [RGB_W-1:0]  iRGB,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [RGB_W-1:0]  oWrData,
    output logic              oWrEn,
    output logic              oFrameDone,
    output logic              oErr,
    output logic              oLocked
);

    // Counters are one bit wider than needed for 2*WIDTH / 2*HEIGHT so overruns stay visible.
    localparam int unsigned XW = $clog2(2 * WIDTH + 1);
    localparam int unsigned YW = $clog2(2 * HEIGHT + 1);

    localparam logic [XW-1:0]     X_END    = XW'(2 * WIDTH);
    localparam logic [YW-1:0]     Y_END    = YW'(2 * HEIGHT);
    localparam logic [XW-1:0]     X_MAX    = '1;
    localparam logic [YW-1:0]     Y_MAX    = '1;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

    logic vs_s1, vs_rise, vs_fall;
    logic blank_s1, blank_rise, blank_fall;
    logic hs_s1;
    rgb_t rgb_s1;

    state_t state_q, state_d;

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] ptr;
    logic              prev_good;

    logic frame_start_c;
    logic line_end_c;
    logic line_start_c;
    logic pixel_c;
    logic x_ok_c;
    logic y_ok_c;
    logic store_c;
    logic frame_good_c;
    logic unused_rise;

    sync_edge_detect #(.RST_VAL(1'b1)) u_vs_edge (
        .clk    (iVGA_CLK),
        .rst_n  (iRST_n),
        .d      (iVS),
        .q      (vs_s1),
        .rise_c (vs_rise),
        .fall_c (vs_fall)
    );

    sync_edge_detect #(.RST_VAL(1'b0)) u_blank_edge (
        .clk    (iVGA_CLK),
        .rst_n  (iRST_n),
        .d      (iBLANK_n),
        .q      (blank_s1),
        .rise_c (blank_rise),
        .fall_c (blank_fall)
    );

    assign unused_rise = vs_rise ^ blank_rise ^ vs_s1;

    // S1 stage for the signals that need no edge detection.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hs_s1  <= 1'b1;
            rgb_s1 <= '0;
        end else begin
            hs_s1  <= iHS;
            rgb_s1 <= rgb_t'(iRGB);
        end
    end

    // Event decode; a frame start masks every line-level event in the same cycle.
    assign frame_start_c = vs_fall;
    assign line_end_c    = blank_fall & (state_q == LINE) & ~frame_start_c;
    assign line_start_c  = blank_s1 & ((state_q == WAIT_ACT) | (state_q == HBLANK)) & ~frame_start_c;
    assign pixel_c       = blank_s1 & (state_q != IDLE) & ~frame_start_c;
    assign x_ok_c        = (x < X_END);
    assign y_ok_c        = (y < Y_END);
    assign store_c       = pixel_c & x_ok_c & y_ok_c & ~x[0] & ~y[0];
    assign frame_good_c  = (y == Y_END) & ~oErr & (state_q != LINE);

    // State register.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; frame start overrides every state.
    always_comb begin
        state_d = state_q;
        if (frame_start_c) begin
            state_d = WAIT_ACT;
        end else begin
            case (state_q)
                IDLE:     state_d = IDLE;
                WAIT_ACT: if (blank_s1)   state_d = LINE;
                LINE:     if (blank_fall) state_d = HBLANK;
                HBLANK:   if (blank_s1)   state_d = LINE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Pixel/line counters, incremental write address, error, frame-done and lock tracking.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x          <= '0;
            y          <= '0;
            base       <= '0;
            ptr        <= '0;
            prev_good  <= 1'b0;
            oWrAddr    <= '0;
            oWrData    <= '0;
            oWrEn      <= 1'b0;
            oFrameDone <= 1'b0;
            oErr       <= 1'b0;
            oLocked    <= 1'b0;
        end else begin
            oWrEn      <= 1'b0;
            oFrameDone <= 1'b0;
            if (frame_start_c) begin
                x          <= '0;
                y          <= '0;
                base       <= '0;
                ptr        <= '0;
                // An aborted line marks the new frame as suspect rather than being lost.
                oErr       <= (state_q == LINE);
                oFrameDone <= frame_good_c;
                oLocked    <= frame_good_c & prev_good;
                prev_good  <= frame_good_c;
            end else begin
                if (pixel_c) begin
                    if (x != X_MAX) begin
                        x <= x + XW'(1);
                    end
                    if (!x_ok_c) begin
                        oErr <= 1'b1;
                    end
                end
                if (store_c) begin
                    oWrEn   <= 1'b1;
                    oWrAddr <= ptr;
                    oWrData <= rgb_s1;
                    ptr     <= ptr + ADDR_W'(1);
                end
                if (line_start_c && !y_ok_c) begin
                    oErr <= 1'b1;
                end
                if ((state_q == LINE) && !hs_s1) begin
                    oErr <= 1'b1;
                end
                if (line_end_c) begin
                    x <= '0;
                    if (y != Y_MAX) begin
                        y <= y + YW'(1);
                    end
                    if (x != X_END) begin
                        oErr <= 1'b1;
                    end
                    // Odd lines are skipped, so the row base advances after each one.
                    if (y[0]) begin
                        base <= base + ROW_STEP;
                        ptr  <= base + ROW_STEP;
                    end else begin
                        ptr  <= base;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture with a write scoreboard, on a scaled-down 16x12 active raster.
module tb_vga_capture;

    localparam int W      = 8;
    localparam int H      = 6;
    localparam int AW     = 6;
    localparam int ACT    = 2 * W;
    localparam int FP     = 2;
    localparam int HSW    = 3;
    localparam int BP     = 3;
    localparam int LINE_T = ACT + FP + HSW + BP;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hs;
    logic          vs;
    logic          blank;
    logic [23:0]   rgb;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          wr_en;
    logic          frame_done;
    logic          err;
    logic          locked;

    wr_t exp_q[$];
    wr_t mon_e;
    int  compared   = 0;
    int  mismatched = 0;
    int  wr_cnt     = 0;
    int  done_cnt   = 0;
    int  max_addr   = 0;
    bit  armed      = 1'b0;
    int  w0;
    int  d0;

    vga_capture #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (AW)
    ) dut (
        .iVGA_CLK   (clk),
        .iRST_n     (rst_n),
        .iHS        (hs),
        .iVS        (vs),
        .iBLANK_n   (blank),
        .iRGB       (rgb),
        .oWrAddr    (wr_addr),
        .oWrData    (wr_data),
        .oWrEn      (wr_en),
        .oFrameDone (frame_done),
        .oErr       (err),
        .oLocked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                check("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
        end
        if (frame_done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input logic h, input logic v, input logic b, input logic [23:0] d);
        @(negedge clk);
        hs    = h;
        vs    = v;
        blank = b;
        rgb   = d;
    endtask

    // One raster line; stop_x >= 0 cuts the line short with iBLANK_n still high.
    task automatic drive_line(input int y, input int npix, input int stop_x);
        wr_t e;
        for (int x = 0; x < npix; x++) begin
            if (x == stop_x) return;
            cyc(1'b1, 1'b1, 1'b1, {8'(x), 8'(y), 8'h5A});
            if (armed && x < 2 * W && y < 2 * H && x % 2 == 0 && y % 2 == 0) begin
                e.addr = AW'((y / 2) * W + x / 2);
                e.data = {8'(x), 8'(y), 8'h5A};
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < FP; i++)  cyc(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < HSW; i++) cyc(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < BP; i++)  cyc(1'b1, 1'b1, 1'b0, '0);
    endtask

    // VS-low line followed by a back-porch line.
    task automatic vs_start();
        for (int i = 0; i < LINE_T; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0);
            if (i == 0) armed = 1'b1;
        end
        for (int i = 0; i < LINE_T; i++) cyc(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic frame_body(input int nlines, input int long_line, input int abort_line, input int abort_x);
        for (int y = 0; y < nlines; y++) begin
            if (y == abort_line) begin
                drive_line(y, ACT, abort_x);
                return;
            end
            drive_line(y, (y == long_line) ? ACT + 1 : ACT, -1);
        end
        for (int i = 0; i < LINE_T; i++) cyc(1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        hs    = 1'b1;
        vs    = 1'b1;
        blank = 1'b0;
        rgb   = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_en",  32'(wr_en),      32'd0);
        check("rst_done",   32'(frame_done), 32'd0);
        check("rst_err",    32'(err),        32'd0);
        check("rst_locked", 32'(locked),     32'd0);
        check("rst_addr",   32'(wr_addr),    32'd0);
        check("rst_data",   32'(wr_data),    32'd0);
        rst_n = 1'b1;

        // Active video before any frame start must not be written.
        drive_line(0, ACT, -1);
        check("pre_vs_writes", 32'(wr_cnt), 32'd0);

        // Frame 1: clean.
        vs_start();
        w0 = wr_cnt;
        frame_body(2 * H, -1, -1, -1);
        check("f1_writes", 32'(wr_cnt - w0), 32'd48);
        check("f1_duty",   32'((wr_cnt - w0) * 4), 32'(ACT * 2 * H));
        check("f1_err",    32'(err), 32'd0);
        check("f1_locked", 32'(locked), 32'd0);
        check("f1_maxaddr", 32'(max_addr), 32'd47);

        // Frame 2: clean; its start reports frame 1 done.
        d0 = done_cnt;
        vs_start();
        check("f1_done",         32'(done_cnt - d0), 32'd1);
        check("locked_after_f1", 32'(locked), 32'd0);
        frame_body(2 * H, -1, -1, -1);

        // Frame 3: line 2 carries one extra pixel.
        d0 = done_cnt;
        vs_start();
        check("f2_done",         32'(done_cnt - d0), 32'd1);
        check("locked_after_f2", 32'(locked), 32'd1);
        frame_body(2 * H, 2, -1, -1);
        check("long_line_err", 32'(err), 32'd1);

        // Frame 4: aborted by VS falling mid-line (line end coincides with frame start).
        d0 = done_cnt;
        vs_start();
        check("f3_no_done",      32'(done_cnt - d0), 32'd0);
        check("locked_drop",     32'(locked), 32'd0);
        check("err_cleared",     32'(err), 32'd0);
        frame_body(2 * H, -1, 4, 6);

        // Frame 5: clean content but tagged by the abort at its start.
        d0 = done_cnt;
        vs_start();
        check("abort_err",     32'(err), 32'd1);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        frame_body(2 * H, -1, -1, -1);
        check("f5_queue_drained", 32'(exp_q.size()), 32'd0);

        // Frame 6: reset pulsed mid-frame.
        d0 = done_cnt;
        vs_start();
        check("f5_no_done", 32'(done_cnt - d0), 32'd0);
        check("f6_err",     32'(err), 32'd0);
        for (int y = 0; y < 4; y++) drive_line(y, ACT, -1);
        drive_line(4, ACT, 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en),      32'd0);
        check("mid_rst_done",  32'(frame_done), 32'd0);
        check("mid_rst_err",   32'(err),        32'd0);
        check("mid_rst_lock",  32'(locked),     32'd0);
        check("mid_rst_addr",  32'(wr_addr),    32'd0);
        check("mid_rst_data",  32'(wr_data),    32'd0);
        armed = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w0 = wr_cnt;
        for (int y = 5; y < 2 * H; y++) drive_line(y, ACT, -1);
        check("post_rst_writes", 32'(wr_cnt - w0), 32'd0);

        // Frame 7: clean capture after reset.
        d0 = done_cnt;
        vs_start();
        check("f6_no_done", 32'(done_cnt - d0), 32'd0);
        w0 = wr_cnt;
        frame_body(2 * H, -1, -1, -1);
        check("f7_writes", 32'(wr_cnt - w0), 32'd48);

        // Frame 8: two lines too many.
        d0 = done_cnt;
        vs_start();
        check("f7_done", 32'(done_cnt - d0), 32'd1);
        w0 = wr_cnt;
        max_addr = 0;
        frame_body(2 * H + 2, -1, -1, -1);
        check("tall_writes", 32'(wr_cnt - w0), 32'd48);
        check("tall_err",    32'(err), 32'd1);
        check("tall_maxaddr", 32'(max_addr), 32'd47);

        d0 = done_cnt;
        vs_start();
        check("tall_no_done",  32'(done_cnt - d0), 32'd0);
        check("final_queue",   32'(exp_q.size()), 32'd0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
